// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative MULT/MULTU (shift-add) and DIV/DIVU (restoring) unit; owns HI/LO.
// Latency: start accepted at E0, 32 CALC edges, FIX writes HI/LO at E33; MTHI/MTLO take 1 edge.
// Backpressure: never aborts an in-flight op; raises stall = busy & (start | hilo_rd) so upstream re-presents.
// Build option: define MULDIV_DIV_EN to include the divider; without it DIV/DIVU are silent no-ops.

module ex_muldiv #(
    parameter int ITER = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    input  logic        hilo_rd,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int             CW       = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0]  LAST_CNT = CW'(ITER - 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_count;
    logic [63:0]     r_acc;      // product, or remainder:quotient
    logic [31:0]     r_mcand;    // multiplicand / divisor magnitude (|b|)
    logic [31:0]     r_mplr;     // multiplier / dividend magnitude (|a|), consumed by shifting
    logic            r_neg_res;  // negate product or quotient in FIX
    logic            r_busy;
    logic            r_done;
    logic [31:0]     r_hi;
    logic [31:0]     r_lo;
`ifdef MULDIV_DIV_EN
    logic            r_is_div;
    logic            r_neg_rem;  // remainder follows the dividend sign
    logic            r_dz;       // divide by zero: result is forced in FIX
    logic [31:0]     r_a_raw;    // raw dividend, returned in HI on divide by zero
`endif

    logic            w_accept;
    logic            w_is_mul;
    logic            w_is_div;
    logic            w_stall_src;
    logic            w_signed;
    logic            w_sa;
    logic            w_sb;
    logic [31:0]     w_mag_a;
    logic [31:0]     w_mag_b;
    logic [31:0]     w_mul_add;
    logic [32:0]     w_mul_sum;
    logic [63:0]     w_mul_next;
    logic [63:0]     w_prod;
`ifdef MULDIV_DIV_EN
    logic [32:0]     w_rem_sh;
    logic [32:0]     w_trial;
    logic            w_q_bit;
    logic [63:0]     w_div_next;
    logic [31:0]     w_quot;
    logic [31:0]     w_rem;
`endif

    // A flushed instruction in EX is a bubble; start is only honoured without flush.
    assign w_accept = start & ~flush;
    assign w_is_mul = (op == OP_MULT) | (op == OP_MULTU);

`ifdef MULDIV_DIV_EN
    assign w_is_div    = (op == OP_DIV) | (op == OP_DIVU);
    assign w_stall_src = start;
`else
    // Without a divider, DIV/DIVU do nothing, so they have no reason to wait either.
    assign w_is_div    = 1'b0;
    assign w_stall_src = start & ~((op == OP_DIV) | (op == OP_DIVU));
`endif

    // MULT and DIV have op[0]=0; only those look at operand signs.
    assign w_signed = ~op[0];
    assign w_sa     = w_signed & a[31];
    assign w_sb     = w_signed & b[31];
    assign w_mag_a  = w_sa ? (~a + 32'd1) : a;
    assign w_mag_b  = w_sb ? (~b + 32'd1) : b;

    // Shift-add step: add multiplicand into the top 33 bits, then shift the whole accumulator right.
    assign w_mul_add  = r_mplr[0] ? r_mcand : 32'd0;
    assign w_mul_sum  = {1'b0, r_acc[63:32]} + {1'b0, w_mul_add};
    assign w_mul_next = {w_mul_sum, r_acc[31:1]};
    assign w_prod     = r_neg_res ? (~r_acc + 64'd1) : r_acc;

`ifdef MULDIV_DIV_EN
    // Restoring step: remainder < divisor, so the 33-bit shifted remainder minus divisor
    // always fits a 33-bit signed value and bit 32 is its sign.
    assign w_rem_sh   = {r_acc[63:32], r_mplr[31]};
    assign w_trial    = w_rem_sh - {1'b0, r_mcand};
    assign w_q_bit    = ~w_trial[32];
    assign w_div_next = {(w_q_bit ? w_trial[31:0] : w_rem_sh[31:0]), r_acc[30:0], w_q_bit};
    assign w_quot     = r_neg_res ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
    assign w_rem      = r_neg_rem ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];
`endif

    assign busy  = r_busy;
    assign done  = r_done;
    assign hi    = r_hi;
    assign lo    = r_lo;
    assign stall = r_busy & (w_stall_src | hilo_rd);

    // Sequencer: accepts ops in IDLE, iterates in CALC, sign-fixes and commits HI/LO in FIX.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplr    <= '0;
            r_neg_res <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
`ifdef MULDIV_DIV_EN
            r_is_div  <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dz      <= 1'b0;
            r_a_raw   <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept && (w_is_mul || w_is_div)) begin
                        r_acc     <= '0;
                        r_count   <= '0;
                        r_mcand   <= w_mag_b;
                        r_mplr    <= w_mag_a;
                        r_neg_res <= w_sa ^ w_sb;
                        r_busy    <= 1'b1;
                        r_state   <= S_CALC;
`ifdef MULDIV_DIV_EN
                        r_is_div  <= w_is_div;
                        r_neg_rem <= w_sa;
                        r_dz      <= (b == 32'd0);
                        r_a_raw   <= a;
`endif
                    end else if (w_accept && (op == OP_MTHI)) begin
                        r_hi <= a;
                    end else if (w_accept && (op == OP_MTLO)) begin
                        r_lo <= a;
                    end
                end
                S_CALC: begin
`ifdef MULDIV_DIV_EN
                    if (r_is_div) begin
                        r_acc  <= w_div_next;
                        r_mplr <= {r_mplr[30:0], 1'b0};
                    end else begin
                        r_acc  <= w_mul_next;
                        r_mplr <= {1'b0, r_mplr[31:1]};
                    end
`else
                    r_acc  <= w_mul_next;
                    r_mplr <= {1'b0, r_mplr[31:1]};
`endif
                    if (r_count == LAST_CNT) begin
                        r_count <= '0;
                        r_state <= S_FIX;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                S_FIX: begin
`ifdef MULDIV_DIV_EN
                    if (r_is_div) begin
                        if (r_dz) begin
                            r_hi <= r_a_raw;
                            r_lo <= 32'hFFFF_FFFF;
                        end else begin
                            r_hi <= w_rem;
                            r_lo <= w_quot;
                        end
                    end else begin
                        r_hi <= w_prod[63:32];
                        r_lo <= w_prod[31:0];
                    end
`else
                    r_hi <= w_prod[63:32];
                    r_lo <= w_prod[31:0];
`endif
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
